snake_game_sequencer: RTL

Central game-flow controller for the snake design. Runs the IDLE/RUN/PAUSED/OVER state machine and generates a one-cycle `tick` enable that advances the snake. The tick rate depends on difficulty level and a boost input. The block also keeps a two-digit BCD score whose digits feed the existing hex_decoder instances directly. It replaces free-running toggled divider clocks with a single-clock-domain enable.

---
 rtl/snake_pkg.sv | 25 ++
 rtl/bcd_score_counter.sv | 46 ++++
 rtl/snake_game_sequencer.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// Shared definitions for the snake game control path: state codes, score
// limit and the board-level default tick dividers.
package snake_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_PAUSED = 2'b10,
    ST_OVER   = 2'b11
  } state_e;

  localparam int SCORE_MAX = 99;

  localparam int DEF_SLOW_DIV  = 25000000;
  localparam int DEF_FAST_DIV  = 10000000;
  localparam int DEF_STEP_DIV  = 2500000;
  localparam int DEF_LEVEL_PTS = 5;
  localparam int DEF_MAX_LEVEL = 4;
  localparam int DEF_CNT_W     = 25;

  function automatic int bcd_value(input logic [3:0] tens, input logic [3:0] ones);
    return int'(tens) * 10 + int'(ones);
  endfunction

endpackage

// File: rtl/bcd_score_counter.sv
// Two-digit BCD counter with synchronous clear and increment, holding at the
// package score limit. Also intended for the high-score register.
module bcd_score_counter
  import snake_pkg::*;
(
  input  logic       clkin,
  input  logic       resetn,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] ones,
  output logic [3:0] tens
);

  logic [3:0] ones_q, ones_d;
  logic [3:0] tens_q, tens_d;

  always_comb begin
    ones_d = ones_q;
    tens_d = tens_q;
    if (clr) begin
      ones_d = 4'd0;
      tens_d = 4'd0;
    end else if (inc && (bcd_value(tens_q, ones_q) < SCORE_MAX)) begin
      if (ones_q == 4'd9) begin
        ones_d = 4'd0;
        tens_d = tens_q + 4'd1;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      ones_q <= 4'd0;
      tens_q <= 4'd0;
    end else begin
      ones_q <= ones_d;
      tens_q <= tens_d;
    end
  end

  assign ones = ones_q;
  assign tens = tens_q;

endmodule

// File: rtl/snake_game_sequencer.sv
// Game-flow controller: IDLE/RUN/PAUSED/OVER FSM, level- and boost-dependent
// tick enable, food-driven level progression and the BCD score.
module snake_game_sequencer
  import snake_pkg::*;
#(
  parameter int SLOW_DIV  = DEF_SLOW_DIV,
  parameter int FAST_DIV  = DEF_FAST_DIV,
  parameter int STEP_DIV  = DEF_STEP_DIV,
  parameter int LEVEL_PTS = DEF_LEVEL_PTS,
  parameter int MAX_LEVEL = DEF_MAX_LEVEL,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic       clkin,
  input  logic       resetn,
  input  logic       start,
  input  logic       pause,
  input  logic       boost,
  input  logic       food_eaten,
  input  logic       game_over,
  output logic       tick,
  output logic [1:0] state,
  output logic [2:0] level,
  output logic [3:0] score_ones,
  output logic [3:0] score_tens
);

  localparam int FOOD_W = (LEVEL_PTS > 1) ? $clog2(LEVEL_PTS) : 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               tick_q, tick_d;
  logic [2:0]         level_q, level_d;
  logic [FOOD_W-1:0]  food_q, food_d;
  logic [31:0]        period;
  int                 base;
  logic               interval_done;
  logic               food_ok;
  logic               restart;

  // Signed base keeps high levels from wrapping below the FAST_DIV floor.
  always_comb begin
    base = SLOW_DIV - int'(level_q) * STEP_DIV;
    if (boost || (base < FAST_DIV)) begin
      period = 32'(FAST_DIV);
    end else begin
      period = 32'(base);
    end
  end

  assign interval_done = (32'(count_q) + 32'd1) >= period;

  always_comb begin
    state_d = state_q;
    restart = 1'b0;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_RUN;
      ST_RUN: begin
        if (game_over)  state_d = ST_OVER;
        else if (pause) state_d = ST_PAUSED;
      end
      ST_PAUSED: begin
        if (game_over)  state_d = ST_OVER;
        else if (pause) state_d = ST_RUN;
      end
      ST_OVER: begin
        if (start) begin
          state_d = ST_RUN;
          restart = 1'b1;
        end
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  // A tick decided in RUN is emitted even if the FSM leaves RUN on the same edge.
  always_comb begin
    tick_d  = 1'b0;
    count_d = count_q;
    case (state_q)
      ST_RUN: begin
        if (interval_done) begin
          tick_d  = 1'b1;
          count_d = '0;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      ST_PAUSED: count_d = count_q;
      default:   count_d = '0;
    endcase
  end

  assign food_ok = (state_q == ST_RUN) && food_eaten && !game_over;

  always_comb begin
    food_d  = food_q;
    level_d = level_q;
    if (restart) begin
      food_d  = '0;
      level_d = 3'd0;
    end else if (food_ok) begin
      if (food_q == FOOD_W'(LEVEL_PTS - 1)) begin
        food_d = '0;
        if (level_q < 3'(MAX_LEVEL)) level_d = level_q + 3'd1;
      end else begin
        food_d = food_q + FOOD_W'(1);
      end
    end
  end

  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      tick_q  <= 1'b0;
      level_q <= 3'd0;
      food_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tick_q  <= tick_d;
      level_q <= level_d;
      food_q  <= food_d;
    end
  end

  bcd_score_counter u_score (
    .clkin  (clkin),
    .resetn (resetn),
    .inc    (food_ok),
    .clr    (restart),
    .ones   (score_ones),
    .tens   (score_tens)
  );

  assign tick  = tick_q;
  assign state = state_q;
  assign level = level_q;

endmodule
